// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions for the load/store unit:
// funct3 codes, response error codes and the access FSM encoding.
package rv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_SIZE     = 2'b11
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

endpackage

// File: rtl/lsu_dmem_port_if.sv
// Execute-stage request channel and response channel of the LSU.
// master = requester (execute stage), slave = lsu_dmem_port.
interface lsu_dmem_port_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);

   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [AWIDTH-1:0] req_addr;
   logic [DWIDTH-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DWIDTH-1:0] resp_rdata;
   logic [1:0]        resp_err;

   modport master (
      output req_valid, req_store, req_funct3,
      output req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_store, req_funct3,
      input  req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/lsu_access_chk.sv
// Combinational legality check of a load/store request:
// size code, natural alignment and containment inside DMEM.
module lsu_access_chk
   import rv_mem_pkg::*;
#(
   parameter int AWIDTH    = 32,
   parameter int MEM_BYTES = 512
) (
   input  logic              store,
   input  logic [2:0]        funct3,
   input  logic [AWIDTH-1:0] addr,
   output err_e              err,
   output logic [2:0]        nbytes
);

   logic              illegal;
   logic              misal;
   logic              oor;
   logic [AWIDTH:0]   end_addr;

   always_comb begin
      nbytes = 3'd0;
      unique case (funct3[1:0])
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         2'b10:   nbytes = 3'd4;
         default: nbytes = 3'd0;
      endcase

      if (store)
         illegal = funct3[2] | (funct3[1:0] == 2'b11);
      else
         illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);

      misal = ((nbytes == 3'd2) & addr[0])
            | ((nbytes == 3'd4) & (addr[1:0] != 2'b00));

      // One extra bit so the end address cannot wrap past zero
      end_addr = {1'b0, addr} + (AWIDTH+1)'(nbytes);
      oor      = end_addr > (AWIDTH+1)'(MEM_BYTES);

      err = ERR_OK;
      if (illegal)
         err = ERR_SIZE;
      else if (misal)
         err = ERR_MISALIGN;
      else if (oor)
         err = ERR_RANGE;
   end

endmodule

// File: rtl/lsu_dmem_port.sv
// LSU initiator for the byte-addressable DMEM: one request at a time,
// a single-cycle DMEM access and a held response until it is taken.
module lsu_dmem_port
   import rv_mem_pkg::*;
#(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MEM_BYTES = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_dmem_port_if.slave    lsu,
   output logic [2:0]        dmem_size,
   output logic              dmem_rw,
   output logic [AWIDTH-1:0] dmem_addr,
   output logic [DWIDTH-1:0] dmem_wdata,
   input  logic [DWIDTH-1:0] dmem_rdata
);

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   err_e              err_q, err_d;

   err_e              chk_err;
   logic [2:0]        chk_nbytes;
   logic [DWIDTH-1:0] wmask;

   lsu_access_chk #(
      .AWIDTH    (AWIDTH),
      .MEM_BYTES (MEM_BYTES)
   ) u_chk (
      .store  (lsu.req_store),
      .funct3 (lsu.req_funct3),
      .addr   (lsu.req_addr),
      .err    (chk_err),
      .nbytes (chk_nbytes)
   );

   // Only the bytes the store actually writes reach DMEM
   always_comb begin
      wmask = '0;
      for (int i = 0; i < DWIDTH / 8; i++)
         wmask[8*i +: 8] = (i < int'(chk_nbytes)) ? 8'hFF : 8'h00;
   end

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (lsu.req_valid) begin
               store_d = lsu.req_store;
               err_d   = chk_err;
               rdata_d = '0;
               if (chk_err != ERR_OK) begin
                  state_d = ST_RESP;
               end else begin
                  state_d  = ST_ACCESS;
                  funct3_d = lsu.req_funct3;
                  addr_d   = lsu.req_addr;
                  wdata_d  = lsu.req_wdata & wmask;
               end
            end
         end
         ST_ACCESS: begin
            rdata_d = store_q ? '0 : dmem_rdata;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (lsu.resp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         store_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= ERR_OK;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign lsu.req_ready  = (state_q == ST_IDLE);
   assign lsu.resp_valid = (state_q == ST_RESP);
   assign lsu.resp_rdata = rdata_q;
   assign lsu.resp_err   = err_q;

   assign dmem_size  = funct3_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_rw    = (state_q == ST_ACCESS) & store_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port against a 512-byte DMEM model.
// Each scenario task checks its own expected values inline.
module tb_lsu_dmem_port;

   logic        clk;
   logic        rst_n;
   logic [2:0]  dmem_size;
   logic        dmem_rw;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   logic [7:0]  mem [512];
   logic [8:0]  ma;
   logic [31:0] mw;

   int vectors;
   int miscompares;

   logic [31:0] rd;
   logic [1:0]  er;
   int          lat;
   int          rwc;

   lsu_dmem_port_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

   lsu_dmem_port #(
      .AWIDTH    (32),
      .DWIDTH    (32),
      .MEM_BYTES (512)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lsu        (bus),
      .dmem_size  (dmem_size),
      .dmem_rw    (dmem_rw),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ma = dmem_addr[8:0];
      mw = {mem[ma + 9'd3], mem[ma + 9'd2], mem[ma + 9'd1], mem[ma]};
      dmem_rdata = mw;
      case (dmem_size[1:0])
         2'b00: dmem_rdata = dmem_size[2] ? {24'h0, mw[7:0]}
                                          : {{24{mw[7]}}, mw[7:0]};
         2'b01: dmem_rdata = dmem_size[2] ? {16'h0, mw[15:0]}
                                          : {{16{mw[15]}}, mw[15:0]};
         default: dmem_rdata = mw;
      endcase
   end

   always @(posedge clk) begin
      if (dmem_rw) begin
         mem[ma] = dmem_wdata[7:0];
         if (dmem_size[1:0] != 2'b00)
            mem[ma + 9'd1] = dmem_wdata[15:8];
         if (dmem_size[1:0] == 2'b10) begin
            mem[ma + 9'd2] = dmem_wdata[23:16];
            mem[ma + 9'd3] = dmem_wdata[31:24];
         end
      end
   end

   task automatic do_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      rwc = 0;
      while (!bus.resp_valid && lat < 8) begin
         if (dmem_rw) rwc++;
         @(negedge clk);
         lat++;
      end
      rd = bus.resp_rdata;
      er = bus.resp_err;
   endtask

   task automatic consume();
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic chk_resp(input string nm, input logic [31:0] erd,
                           input logic [1:0] eer, input int elat,
                           input int erwc);
      vectors++;
      if (rd !== erd) begin
         miscompares++;
         $display("FAIL %s rdata got %h want %h", nm, rd, erd);
      end
      vectors++;
      if (er !== eer) begin
         miscompares++;
         $display("FAIL %s err got %b want %b", nm, er, eer);
      end
      vectors++;
      if (lat !== elat) begin
         miscompares++;
         $display("FAIL %s latency got %0d want %0d", nm, lat, elat);
      end
      vectors++;
      if (rwc !== erwc) begin
         miscompares++;
         $display("FAIL %s rw_cycles got %0d want %0d", nm, rwc, erwc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({bus.resp_valid, dmem_rw} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_ctl got %b want 00", {bus.resp_valid, dmem_rw});
      end
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_ready got %b want 1", bus.req_ready);
      end
      vectors++;
      if ({bus.resp_rdata, bus.resp_err} !== 34'h0) begin
         miscompares++;
         $display("FAIL rst_resp got %h/%b want 0/00", bus.resp_rdata, bus.resp_err);
      end
      vectors++;
      if ({dmem_addr, dmem_wdata, dmem_size} !== 67'h0) begin
         miscompares++;
         $display("FAIL rst_dmem got %h/%h/%b want 0", dmem_addr, dmem_wdata, dmem_size);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word();
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      chk_resp("sw_10", 32'h0, 2'b00, 2, 1);
      consume();
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk_resp("lw_10", 32'hDEADBEEF, 2'b00, 2, 0);
      consume();
   endtask

   task automatic test_byte();
      do_req(1'b1, 3'b000, 32'h20, 32'h12345680);
      chk_resp("sb_20", 32'h0, 2'b00, 2, 1);
      consume();
      do_req(1'b0, 3'b000, 32'h20, 32'h0);
      chk_resp("lb_20", 32'hFFFFFF80, 2'b00, 2, 0);
      consume();
      do_req(1'b0, 3'b100, 32'h20, 32'h0);
      chk_resp("lbu_20", 32'h00000080, 2'b00, 2, 0);
      consume();
   endtask

   task automatic test_misalign();
      do_req(1'b0, 3'b001, 32'h21, 32'h0);
      chk_resp("lh_21", 32'h0, 2'b01, 1, 0);
      consume();
      do_req(1'b0, 3'b010, 32'h22, 32'h0);
      chk_resp("lw_22", 32'h0, 2'b01, 1, 0);
      consume();
   endtask

   task automatic test_range();
      do_req(1'b0, 3'b010, 32'h1FC, 32'h0);
      chk_resp("lw_1fc", 32'h0, 2'b00, 2, 0);
      consume();
      do_req(1'b0, 3'b010, 32'h200, 32'h0);
      chk_resp("lw_200", 32'h0, 2'b10, 1, 0);
      consume();
      do_req(1'b1, 3'b001, 32'h1FF, 32'hFFFF);
      chk_resp("sh_1ff", 32'h0, 2'b01, 1, 0);
      consume();
   endtask

   task automatic test_illegal();
      do_req(1'b0, 3'b011, 32'h40, 32'h0);
      chk_resp("ld_f3_3", 32'h0, 2'b11, 1, 0);
      consume();
      do_req(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF);
      chk_resp("st_f3_4", 32'h0, 2'b11, 1, 0);
      consume();
      vectors++;
      if (mem[64] !== 8'h00) begin
         miscompares++;
         $display("FAIL st_f3_4_mem got %h want 00", mem[64]);
      end
   endtask

   task automatic test_backpressure();
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk_resp("bp_lw", 32'hDEADBEEF, 2'b00, 2, 0);
      // A competing store must be ignored while the response waits
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.resp_valid, bus.req_ready, dmem_rw} !== 3'b100) begin
            miscompares++;
            $display("FAIL bp_ctl_%0d got %b want 100", i,
                     {bus.resp_valid, bus.req_ready, dmem_rw});
         end
         vectors++;
         if ({bus.resp_rdata, bus.resp_err} !== {32'hDEADBEEF, 2'b00}) begin
            miscompares++;
            $display("FAIL bp_data_%0d got %h/%b want deadbeef/00", i,
                     bus.resp_rdata, bus.resp_err);
         end
      end
      bus.req_valid = 1'b0;
      consume();
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk_resp("bp_relw", 32'hDEADBEEF, 2'b00, 2, 0);
      consume();
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h30;
      bus.req_wdata  = 32'hCAFEF00D;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      vectors++;
      if (dmem_rw !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_rw_pre got %b want 1", dmem_rw);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({dmem_rw, bus.resp_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL abort_ctl got %b want 00", {dmem_rw, bus.resp_valid});
      end
      vectors++;
      if ({dmem_addr, dmem_wdata, bus.resp_rdata} !== 96'h0) begin
         miscompares++;
         $display("FAIL abort_zero got %h/%h/%h want 0", dmem_addr, dmem_wdata,
                  bus.resp_rdata);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({mem[51], mem[50], mem[49], mem[48]} !== 32'h0) begin
         miscompares++;
         $display("FAIL abort_mem got %h want 00000000",
                  {mem[51], mem[50], mem[49], mem[48]});
      end
      vectors++;
      if (bus.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_resp got %b want 0", bus.resp_valid);
      end
      do_req(1'b0, 3'b010, 32'h30, 32'h0);
      chk_resp("abort_lw", 32'h0, 2'b00, 2, 0);
      consume();
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;

      test_reset();
      test_word();
      test_byte();
      test_misalign();
      test_range();
      test_illegal();
      test_backpressure();
      test_reset_abort();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
